// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC actuator stage: state encoding and default timing.
package hvac_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEAT    = 2'd1;
    localparam logic [1:0] ST_COOL    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    localparam int unsigned DEF_MIN_ON      = 8;
    localparam int unsigned DEF_MIN_OFF     = 6;
    localparam int unsigned DEF_FAN_OVERRUN = 4;
    localparam int unsigned DEF_CNT_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_HEAT    = ST_HEAT,
        S_COOL    = ST_COOL,
        S_LOCKOUT = ST_LOCKOUT
    } state_t;

endpackage

// File: rtl/hvac_actuator_ctrl_if.sv
// Request/drive bundle between the ac controller, this stage and the plant.
interface hvac_actuator_ctrl_if;

    logic heating_req;
    logic cooling_req;
    logic heater_en;
    logic cooler_en;
    logic fan_en;
    logic lockout;
    logic req_err;

    // Side issuing the requests and observing the drives.
    modport master (
        output heating_req, cooling_req,
        input  heater_en, cooler_en, fan_en, lockout, req_err
    );

    // The actuator controller itself.
    modport slave (
        input  heating_req, cooling_req,
        output heater_en, cooler_en, fan_en, lockout, req_err
    );

endinterface

// File: rtl/hvac_dwell_counter.sv
// Saturating dwell counter: load-to-1 on state entry, count up to a limit, never wrap.
module hvac_dwell_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise increment until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(1);
        end else if (en_i && (count_q < limit_i)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/hvac_actuator_ctrl.sv
// Turns heat/cool requests into heater/cooler/fan drives with min-on, min-off
// lockout, forced changeover through lockout and fan overrun.
module hvac_actuator_ctrl
    import hvac_pkg::*;
#(
    parameter int unsigned MIN_ON      = DEF_MIN_ON,
    parameter int unsigned MIN_OFF     = DEF_MIN_OFF,
    parameter int unsigned FAN_OVERRUN = DEF_FAN_OVERRUN,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    hvac_actuator_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);
    localparam logic [CNT_W-1:0] FAN_OVR_C = CNT_W'(FAN_OVERRUN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d, dwell_limit;
    logic             dwell_load, dwell_en;
    logic             single_heat, single_cool;

    logic heater_en_q, heater_en_d;
    logic cooler_en_q, cooler_en_d;
    logic fan_en_q,    fan_en_d;
    logic lockout_q,   lockout_d;
    logic req_err_q,   req_err_d;

    assign single_heat = bus.heating_req & ~bus.cooling_req;
    assign single_cool = bus.cooling_req & ~bus.heating_req;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (single_heat)      state_d = S_HEAT;
                else if (single_cool) state_d = S_COOL;
            end
            S_HEAT: begin
                if (!bus.heating_req && dwell_q == MIN_ON_C) state_d = S_LOCKOUT;
            end
            S_COOL: begin
                if (!bus.cooling_req && dwell_q == MIN_ON_C) state_d = S_LOCKOUT;
            end
            S_LOCKOUT: begin
                if (dwell_q == MIN_OFF_C) begin
                    if (single_heat)      state_d = S_HEAT;
                    else if (single_cool) state_d = S_COOL;
                    else                  state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One counter serves every timed state; it restarts at 1 on each entry.
    assign dwell_load  = (state_d != state_q) && (state_d != S_IDLE);
    assign dwell_en    = (state_d != S_IDLE);
    assign dwell_limit = (state_d == S_LOCKOUT) ? MIN_OFF_C : MIN_ON_C;

    hvac_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk          (clk),
        .rst          (rst),
        .load_i       (dwell_load),
        .en_i         (dwell_en),
        .limit_i      (dwell_limit),
        .count_o      (dwell_q),
        .count_next_o (dwell_d)
    );

    // Output decode from next state/dwell so registered drives line up with the state register.
    always_comb begin
        heater_en_d = (state_d == S_HEAT);
        cooler_en_d = (state_d == S_COOL);
        lockout_d   = (state_d == S_LOCKOUT);
        fan_en_d    = heater_en_d | cooler_en_d | (lockout_d && (dwell_d <= FAN_OVR_C));
        req_err_d   = bus.heating_req & bus.cooling_req;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            heater_en_q <= 1'b0;
            cooler_en_q <= 1'b0;
            fan_en_q    <= 1'b0;
            lockout_q   <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            heater_en_q <= heater_en_d;
            cooler_en_q <= cooler_en_d;
            fan_en_q    <= fan_en_d;
            lockout_q   <= lockout_d;
            req_err_q   <= req_err_d;
        end
    end

    assign bus.heater_en = heater_en_q;
    assign bus.cooler_en = cooler_en_q;
    assign bus.fan_en    = fan_en_q;
    assign bus.lockout   = lockout_q;
    assign bus.req_err   = req_err_q;

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// Scoreboard bench for hvac_actuator_ctrl: directed scenarios followed by random
// request bursts, checked against a timestamp-based model of the plant rules.
module tb_hvac_actuator_ctrl;
    import hvac_pkg::*;

    localparam int MIN_ON  = DEF_MIN_ON;
    localparam int MIN_OFF = DEF_MIN_OFF;
    localparam int FAN_OVR = DEF_FAN_OVERRUN;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hvac_actuator_ctrl_if bus ();

    hvac_actuator_ctrl #(
        .MIN_ON      (DEF_MIN_ON),
        .MIN_OFF     (DEF_MIN_OFF),
        .FAN_OVERRUN (DEF_FAN_OVERRUN),
        .CNT_W       (DEF_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {heater, cooler, fan, lockout, req_err} after each edge.
    logic [4:0] exp_q[$];

    // Reference model: mode plus the edge number at which it was entered.
    // 0 = idle, 1 = heating run, 2 = cooling run, 3 = enforced off period.
    int m_mode  = 0;
    int m_entry = 0;
    int m_t     = 0;

    function automatic logic [4:0] model_step(input bit h, input bit c, input bit r);
        int  dt;
        int  k;
        bit  fan;
        m_t = m_t + 1;
        if (r) begin
            m_mode = 0;
            return 5'b0;
        end
        dt = m_t - m_entry;
        case (m_mode)
            0: begin
                if (h && !c)      begin m_mode = 1; m_entry = m_t; end
                else if (c && !h) begin m_mode = 2; m_entry = m_t; end
            end
            1: if (!h && dt >= MIN_ON) begin m_mode = 3; m_entry = m_t; end
            2: if (!c && dt >= MIN_ON) begin m_mode = 3; m_entry = m_t; end
            default: begin
                if (dt >= MIN_OFF) begin
                    if (h && !c)      begin m_mode = 1; m_entry = m_t; end
                    else if (c && !h) begin m_mode = 2; m_entry = m_t; end
                    else              m_mode = 0;
                end
            end
        endcase
        k   = m_t - m_entry + 1;
        fan = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && k <= FAN_OVR);
        return {m_mode == 1, m_mode == 2, fan, m_mode == 3, h && c};
    endfunction

    task automatic drive(input bit h, input bit c, input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.heating_req = h;
            bus.cooling_req = c;
            rst             = r;
            exp_q.push_back(model_step(h, c, r));
        end
    endtask

    // Monitor: compares each presented output set with the scoreboard head.
    logic prev_heat = 1'b0;
    logic prev_cool = 1'b0;
    initial begin
        logic [4:0] e;
        logic [4:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.heater_en, bus.cooler_en, bus.fan_en, bus.lockout, bus.req_err};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got(h,c,f,l,e)=%b exp=%b", $time, got, e);
                end
                checks++;
                if (bus.heater_en && bus.cooler_en) begin
                    errors++;
                    $display("FAIL both_drives t=%0t got=11 exp=not both", $time);
                end
                checks++;
                if ((prev_heat && bus.cooler_en) || (prev_cool && bus.heater_en)) begin
                    errors++;
                    $display("FAIL adjacent_changeover t=%0t prev(h,c)=%b%b now(h,c)=%b%b",
                             $time, prev_heat, prev_cool, bus.heater_en, bus.cooler_en);
                end
                checks++;
                if ((bus.heater_en || bus.cooler_en) && !bus.fan_en) begin
                    errors++;
                    $display("FAIL fan_with_drive t=%0t fan=%b exp=1", $time, bus.fan_en);
                end
                prev_heat = bus.heater_en;
                prev_cool = bus.cooler_en;
            end
        end
    end

    initial begin
        int hold;
        int pick;
        bit rh, rc, rr;
        bus.heating_req = 1'b1;
        bus.cooling_req = 1'b0;

        // Reset held with a heat request, then release.
        drive(1, 0, 1, 3);
        drive(1, 0, 0, 2);
        drive(0, 0, 0, 20);
        // Short heat pulse.
        drive(1, 0, 0, 2);
        drive(0, 0, 0, 25);
        // Heat held, then immediate changeover to cool.
        drive(1, 0, 0, 20);
        drive(0, 1, 0, 20);
        drive(0, 0, 0, 20);
        // Conflicting requests in idle.
        drive(1, 1, 0, 3);
        drive(0, 0, 0, 3);
        // Reset in the middle of a cooling run.
        drive(0, 1, 0, 3);
        drive(0, 1, 1, 1);
        drive(0, 0, 0, 15);
        // Long heat run, well past counter saturation.
        drive(1, 0, 0, 300);
        drive(0, 0, 0, 20);

        // Random request bursts with occasional resets.
        for (int b = 0; b < 300; b++) begin
            pick = $urandom_range(0, 9);
            rh   = (pick < 4) || (pick == 9);
            rc   = (pick >= 4 && pick < 7) || (pick == 9);
            hold = $urandom_range(1, 14);
            rr   = ($urandom_range(0, 39) == 0);
            if (rr) drive(rh, rc, 1, $urandom_range(1, 2));
            drive(rh, rc, 0, hold);
        end
        drive(0, 0, 0, 15);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
